// File: rtl/ctrl_issue_queue.sv
// Issue stage: buffers opcodes from fetch in a small FIFO, presents the FIFO head to the
// external combinational control decoder, and captures the decoded control word into a
// registered output stage with a valid/ready handshake toward execute.
module ctrl_issue_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [6:0]                 in_opcode,
   output logic [6:0]                 dec_opcode,
   input  logic [25:0]                dec_ctrl,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [6:0]                 out_opcode,
   output logic [25:0]                out_ctrl,
   output logic [$clog2(DEPTH):0]     occupancy,
   output logic [CNT_W-1:0]           issued_count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned OW = PW + 1;
   localparam logic [OW-1:0] FullCnt = OW'(DEPTH);

   logic [6:0]       mem_q [DEPTH];
   logic [PW-1:0]    rptr_q, rptr_d;
   logic [PW-1:0]    wptr_q, wptr_d;
   logic [OW-1:0]    occ_q, occ_d;
   logic             out_valid_q, out_valid_d;
   logic [6:0]       out_opcode_q, out_opcode_d;
   logic [25:0]      out_ctrl_q, out_ctrl_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic push, pop, stage_free, fifo_empty, out_fire;

   // Handshake qualifiers; in_ready deliberately ignores a same-cycle pop.
   always_comb begin
      fifo_empty = (occ_q == '0);
      in_ready   = (occ_q != FullCnt) & ~flush & ~rst;
      push       = in_valid & in_ready;
      stage_free = ~out_valid_q | out_ready;
      pop        = ~fifo_empty & stage_free & ~flush;
      out_fire   = out_valid_q & out_ready;
      dec_opcode = fifo_empty ? 7'd0 : mem_q[rptr_q];
   end

   // Next-state for pointers, occupancy, output stage and issued counter.
   always_comb begin
      rptr_d       = rptr_q;
      wptr_d       = wptr_q;
      occ_d        = occ_q;
      out_valid_d  = out_valid_q;
      out_opcode_d = out_opcode_q;
      out_ctrl_d   = out_ctrl_q;
      cnt_d        = cnt_q;

      // A handshake in a flush cycle still counts.
      if (out_fire) begin
         cnt_d = cnt_q + 1'b1;
      end

      if (flush) begin
         rptr_d      = '0;
         wptr_d      = '0;
         occ_d       = '0;
         out_valid_d = 1'b0;
      end else begin
         if (push) begin
            wptr_d = wptr_q + 1'b1;
         end
         if (pop) begin
            rptr_d       = rptr_q + 1'b1;
            out_valid_d  = 1'b1;
            out_opcode_d = dec_opcode;
            out_ctrl_d   = dec_ctrl;
         end else if (out_fire) begin
            out_valid_d = 1'b0;
         end
         unique case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
         endcase
      end
   end

   // Control state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         rptr_q       <= '0;
         wptr_q       <= '0;
         occ_q        <= '0;
         out_valid_q  <= 1'b0;
         out_opcode_q <= '0;
         out_ctrl_q   <= '0;
         cnt_q        <= '0;
      end else begin
         rptr_q       <= rptr_d;
         wptr_q       <= wptr_d;
         occ_q        <= occ_d;
         out_valid_q  <= out_valid_d;
         out_opcode_q <= out_opcode_d;
         out_ctrl_q   <= out_ctrl_d;
         cnt_q        <= cnt_d;
      end
   end

   // FIFO storage; contents are don't-care while the occupancy says empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q] <= in_opcode;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_opcode   = out_opcode_q;
   assign out_ctrl     = out_ctrl_q;
   assign occupancy    = occ_q;
   assign issued_count = cnt_q;

endmodule

// File: tb/tb_ctrl_issue_queue.sv
// Directed bench for ctrl_issue_queue. A second instance with CNT_W=4 shares the stimulus
// and is used to observe counter wrap.
module tb_ctrl_issue_queue;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic [6:0]  in_opcode;

   logic        in_ready, out_valid;
   logic [6:0]  dec_opcode, out_opcode;
   logic [25:0] dec_ctrl, out_ctrl;
   logic [2:0]  occupancy;
   logic [15:0] issued_count;

   logic        in_ready4, out_valid4;
   logic [6:0]  dec_opcode4, out_opcode4;
   logic [25:0] dec_ctrl4, out_ctrl4;
   logic [2:0]  occupancy4;
   logic [3:0]  issued_count4;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   // Stand-in for the control decoder.
   function automatic logic [25:0] model(input logic [6:0] op);
      if (op == 7'h15) return 26'h2AB_CDEF;
      return {op, 12'hA5C ^ {5'b0, op}, ~op};
   endfunction

   assign dec_ctrl  = model(dec_opcode);
   assign dec_ctrl4 = model(dec_opcode4);

   ctrl_issue_queue #(.DEPTH(4), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .dec_opcode(dec_opcode), .dec_ctrl(dec_ctrl),
      .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
      .out_ctrl(out_ctrl), .occupancy(occupancy), .issued_count(issued_count)
   );

   ctrl_issue_queue #(.DEPTH(4), .CNT_W(4)) u_dut4 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
      .in_opcode(in_opcode), .dec_opcode(dec_opcode4), .dec_ctrl(dec_ctrl4),
      .out_valid(out_valid4), .out_ready(out_ready), .out_opcode(out_opcode4),
      .out_ctrl(out_ctrl4), .occupancy(occupancy4), .issued_count(issued_count4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin : stim
      int          hs;
      int          pushed;
      logic [6:0]  next_in;
      logic [6:0]  exp_out;
      logic        do_hs;
      logic        hold;
      logic [25:0] saved;

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_opcode = '0;
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("rst_occ",       32'(occupancy),    0);
      chk("rst_valid",     32'(out_valid),    0);
      chk("rst_opcode",    32'(out_opcode),   0);
      chk("rst_ctrl",      32'(out_ctrl),     0);
      chk("rst_count",     32'(issued_count), 0);
      chk("rst_in_ready",  32'(in_ready),     1);
      chk("rst_dec_op",    32'(dec_opcode),   0);

      // Single word, one-cycle latency from the push edge.
      out_ready = 1'b1; in_valid = 1'b1; in_opcode = 7'h15;
      tick();
      in_valid = 1'b0;
      chk("t1_occ",        32'(occupancy),    1);
      chk("t1_dec_op",     32'(dec_opcode),   32'h15);
      chk("t1_nobypass",   32'(out_valid),    0);
      tick();
      chk("t1_valid",      32'(out_valid),    1);
      chk("t1_opcode",     32'(out_opcode),   32'h15);
      chk("t1_ctrl",       32'(out_ctrl),     32'h2AB_CDEF);
      chk("t1_cnt0",       32'(issued_count), 0);
      tick();
      chk("t1_cnt1",       32'(issued_count), 1);
      chk("t1_idle",       32'(out_valid),    0);

      // Fill with out_ready low, then drain in order.
      out_ready = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         in_valid = 1'b1; in_opcode = 7'(k);
         tick();
      end
      chk("t2_occ_full",   32'(occupancy),    4);
      chk("t2_stage_op",   32'(out_opcode),   1);
      in_opcode = 7'h06;
      #1;
      chk("t2_in_ready0",  32'(in_ready),     0);
      tick();
      in_valid = 1'b0;
      chk("t2_no_accept",  32'(occupancy),    4);
      out_ready = 1'b1;
      for (int k = 2; k <= 5; k++) begin
         tick();
         chk("t2_drain_op",  32'(out_opcode), 32'(k));
         chk("t2_drain_vld", 32'(out_valid),  1);
         chk("t2_drain_occ", 32'(occupancy),  32'(5 - k));
      end
      tick();
      chk("t2_empty_vld",  32'(out_valid),    0);
      chk("t2_hold_op",    32'(out_opcode),   5);
      chk("t2_count",      32'(issued_count), 6);

      // Continuous input against a toggling out_ready.
      next_in = 7'h20; exp_out = 7'h20; hs = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         out_ready = (cyc % 2 == 0);
         in_valid  = (next_in < 7'h28);
         in_opcode = next_in;
         #1;
         if (in_valid && in_ready) next_in++;
         if (out_valid && out_ready) begin
            chk("t3_order", 32'(out_opcode), 32'(exp_out));
            chk("t3_ctrl",  32'(out_ctrl),   32'(model(exp_out)));
            exp_out++;
            hs++;
         end
         hold  = out_valid && !out_ready;
         saved = out_ctrl;
         tick();
         if (hold) chk("t3_stable", 32'(out_ctrl), 32'(saved));
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick(); tick();
      chk("t3_all_out",    32'(exp_out),      32'h28);
      chk("t3_hs",         32'(hs),           8);
      chk("t3_count",      32'(issued_count), 14);
      chk("t3_count4",     32'(issued_count4), 14);
      chk("t3_idle",       32'(out_valid),    0);

      // Flush with a stalled stage: count unchanged.
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1; in_opcode = 7'(8'h30 + k);
         tick();
      end
      in_valid = 1'b0;
      chk("t4_occ3",       32'(occupancy),    3);
      chk("t4_vld",        32'(out_valid),    1);
      flush = 1'b1;
      #1;
      chk("t4_ready_fl",   32'(in_ready),     0);
      tick();
      flush = 1'b0;
      #1;
      chk("t4_fl_occ",     32'(occupancy),    0);
      chk("t4_fl_vld",     32'(out_valid),    0);
      chk("t4_fl_ready",   32'(in_ready),     1);
      chk("t4_fl_cnt",     32'(issued_count), 14);
      chk("t4_fl_dec",     32'(dec_opcode),   0);
      // Flush during a handshake: that word counts.
      in_valid = 1'b1; in_opcode = 7'h34;
      tick();
      in_valid = 1'b0;
      tick();
      chk("t4_vld2",       32'(out_valid),    1);
      out_ready = 1'b1; flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t4_fl2_cnt",    32'(issued_count), 15);
      chk("t4_fl2_vld",    32'(out_valid),    0);

      // Counter wrap on the CNT_W=4 instance, from a fresh reset.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      pushed = 0; hs = 0;
      for (int cyc = 0; cyc < 40 && hs < 17; cyc++) begin
         in_valid  = (pushed < 17);
         in_opcode = 7'(8'h50 + pushed);
         #1;
         if (in_valid && in_ready) pushed++;
         do_hs = out_valid && out_ready;
         tick();
         if (do_hs) begin
            hs++;
            chk("t5_count4", 32'(issued_count4), 32'(hs % 16));
            chk("t5_count",  32'(issued_count),  32'(hs));
         end
      end
      in_valid = 1'b0;
      chk("t5_hs_total",   32'(hs),           17);

      // Reset mid-stream.
      tick(); tick();
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; in_opcode = 7'(8'h40 + k);
         tick();
      end
      in_valid = 1'b0;
      chk("t6_occ2",       32'(occupancy),    2);
      chk("t6_vld",        32'(out_valid),    1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("t6_occ",        32'(occupancy),    0);
      chk("t6_vld0",       32'(out_valid),    0);
      chk("t6_op0",        32'(out_opcode),   0);
      chk("t6_ctrl0",      32'(out_ctrl),     0);
      chk("t6_cnt0",       32'(issued_count), 0);
      chk("t6_ready",      32'(in_ready),     1);
      out_ready = 1'b1; in_valid = 1'b1; in_opcode = 7'h45;
      tick();
      in_valid = 1'b0;
      tick();
      chk("t6_new_vld",    32'(out_valid),    1);
      chk("t6_new_op",     32'(out_opcode),   32'h45);
      chk("t6_new_ctrl",   32'(out_ctrl),     32'(model(7'h45)));
      tick();
      chk("t6_new_cnt",    32'(issued_count), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ctrl_issue_queue.md
Name: ctrl_issue_queue

Overview:
- Sequential issue stage that wraps the combinational 7-in/26-out control decoder.
- Buffers incoming 7-bit opcodes from the fetch side in a small FIFO and presents the FIFO head to the decoder.
- Captures the decoder's 26-bit control word into a registered output stage with a valid/ready handshake toward execute.
- Counts issued control words and supports a synchronous flush.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the issued-word counter.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous discard of all buffered and staged opcodes.
- in_valid  input  1  upstream opcode valid.
- in_ready  output  1  FIFO can accept an opcode.
- in_opcode  input  7  opcode; bit i maps to decoder input pi<i>.
- dec_opcode  output  7  FIFO head driven to the decoder; 0 when FIFO empty.
- dec_ctrl  input  26  decoder result for dec_opcode; bit i is po<i>; same-cycle combinational.
- out_valid  output  1  output stage holds a control word.
- out_ready  input  1  downstream accepts the word.
- out_opcode  output  7  opcode of the staged word.
- out_ctrl  output  26  staged control word.
- occupancy  output  $clog2(DEPTH)+1  FIFO entry count; excludes the output stage.
- issued_count  output  CNT_W  number of completed output handshakes.

Behaviour:
- Reset (rst=1 at an edge): FIFO emptied, read/write pointers 0, occupancy 0, out_valid 0, out_opcode 0, out_ctrl 0, issued_count 0. in_ready reads 1 on the cycle after reset.
- rst has priority over flush and over all handshakes.
- push = in_valid & in_ready.
- in_ready = (occupancy != DEPTH) & ~flush & ~rst. It does not depend on same-cycle pop.
- stage_free = ~out_valid | out_ready.
- pop = (occupancy != 0) & stage_free & ~flush.
- On pop: out_opcode <= head, out_ctrl <= dec_ctrl sampled that cycle, out_valid <= 1, read pointer advances.
- When out_valid & out_ready & ~pop: out_valid <= 0. out_opcode and out_ctrl hold their last values.
- No bypass. An opcode pushed at edge E is at the head after E; the earliest out_valid is after edge E+1.
  - One-cycle latency from the push edge; two cycles from in_valid assertion into an empty block with out_ready=1.
- Simultaneous push and pop: occupancy unchanged, both pointers advance.
- A push into a FIFO with occupancy DEPTH-1 that also pops leaves occupancy at DEPTH-1.
- Pointers wrap modulo DEPTH. Full/empty is decided by occupancy, not by pointer equality.
- Throughput: one word per cycle sustained when out_ready is held at 1 and the FIFO is non-empty.
- Output stability: while out_valid=1 and out_ready=0, out_opcode and out_ctrl hold. No new pop occurs in that state.
- Flush (flush=1, rst=0):
  - Next cycle: occupancy 0, pointers 0, out_valid 0.
  - No push and no pop that cycle.
  - A handshake on out_valid & out_ready in the flush cycle still counts toward issued_count.
- issued_count increments by 1 on each edge where out_valid & out_ready. It wraps from 2^CNT_W-1 to 0 and is cleared only by rst.
- dec_ctrl is sampled only on pop cycles. Its value on other cycles, including bit 23 (decoder constant 1), is ignored.
- Reset asserted mid-stream discards all words regardless of handshake state; no partial word is emitted.

Test Plan:
- Reset, then push opcode 7'h15 with out_ready=1; decoder model returns 26'h2AB_CDEF for 7'h15 -> out_valid=1 one edge after the push edge, out_opcode=7'h15, out_ctrl=26'h2AB_CDEF, issued_count=1 after the handshake edge.
- out_ready=0, push 5 opcodes 0x01..0x05 (DEPTH=4) -> 0x01 moves to the stage. 0x02..0x05 fill the FIFO, occupancy=4, in_ready=0. A 6th opcode is not accepted. Raising out_ready drains in order 0x01..0x05 on consecutive cycles.
- out_ready toggling 1,0,1,0 during continuous input -> no word lost or duplicated. out_ctrl is stable while out_valid=1 and out_ready=0. issued_count equals the number of handshakes.
- Assert flush with occupancy=3 and out_valid=1, out_ready=0 -> next cycle occupancy=0, out_valid=0, in_ready=1. issued_count unchanged. Flush with out_ready=1 -> count +1.
- CNT_W=4: 17 handshakes -> issued_count reads 15 then 0 then 1.
- Assert rst while occupancy=2 and out_valid=1 -> next cycle all outputs 0 and in_ready=1. A new push afterwards is issued normally.
